// File: rtl/btn_go_ctrl.sv
// ---------------------------------------------------------------------------
// btn_go_ctrl
//   Turns a raw, bouncing push-button into clean control events for the LED
//   sequencer and the timer control logic. The button is brought into the
//   i_clk domain with a two-flop synchronizer, normalised to active-high and
//   then debounced against the shared 1 kHz tick in both directions.
//
// Ports
//   i_clk      : system clock
//   i_rstn     : asynchronous active-low reset
//   i_pls_1k   : one-clock tick every 1 ms, synchronous to i_clk
//   i_btn      : raw button, asynchronous, bouncing
//   o_go       : one-clock pulse per debounced press (sequencer go input)
//   o_release  : one-clock pulse per debounced release
//   o_long     : one-clock pulse, at most once per press, after LONG_MS held
//   o_pressed  : debounced button level, active-high
// ---------------------------------------------------------------------------
module btn_go_ctrl #(
  parameter int unsigned DEB_MS      = 32'd20,
  parameter int unsigned LONG_MS     = 32'd1000,
  parameter bit          BTN_ACT_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_pls_1k,
  input  logic i_btn,
  output logic o_go,
  output logic o_release,
  output logic o_long,
  output logic o_pressed
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_DEB   = 2'd3;

  // Terminal counts are compared one below the parameter so the counters
  // never need to hold the parameter value itself (fits 16 bits for 65535).
  localparam logic [15:0] DEB_LAST  = 16'(DEB_MS - 32'd1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 32'd1);

  // Released level of the raw pin, used as the synchronizer reset value so
  // that reset never looks like a press.
  localparam logic BTN_IDLE_LVL = BTN_ACT_LOW;

  logic [1:0]  sync_r;
  logic        btn_s;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [15:0] r_deb;
  logic [15:0] deb_nxt_s;
  logic [15:0] r_hold;
  logic [15:0] hold_nxt_s;
  logic        long_done_r;
  logic        long_done_nxt_s;
  logic        go_nxt_s;
  logic        rel_nxt_s;
  logic        long_nxt_s;
  logic        pressed_nxt_s;

  // Two-flop synchronizer; nothing downstream looks at i_btn before sync_r[1].
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_r <= {2{BTN_IDLE_LVL}};
    end else begin
      sync_r <= {sync_r[0], i_btn};
    end
  end

  // XOR with the polarity bit yields an active-high pressed level.
  assign btn_s = sync_r[1] ^ BTN_ACT_LOW;

  // Debounce / hold state machine. A btn_s change always wins over a tick in
  // the same cycle, so any bounce restarts the window from zero.
  always_comb begin
    state_nxt_s     = state_r;
    deb_nxt_s       = r_deb;
    hold_nxt_s      = r_hold;
    long_done_nxt_s = long_done_r;
    go_nxt_s        = 1'b0;
    rel_nxt_s       = 1'b0;
    long_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt_s = ST_PRESS_DEB;
          deb_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESS_DEB: begin
        if (!btn_s) begin
          state_nxt_s = ST_IDLE;
        end else if (i_pls_1k) begin
          if (r_deb == DEB_LAST) begin
            state_nxt_s     = ST_HELD;
            hold_nxt_s      = 16'd0;
            long_done_nxt_s = 1'b0;
            go_nxt_s        = 1'b1;
          end else begin
            deb_nxt_s = r_deb + 16'd1;
          end
        end else begin
          state_nxt_s = ST_PRESS_DEB;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_nxt_s = ST_REL_DEB;
          deb_nxt_s   = 16'd0;
        end else if (i_pls_1k && !long_done_r) begin
          // Hold count stops at LONG_MS-1 once long_done is set.
          if (r_hold == LONG_LAST) begin
            long_done_nxt_s = 1'b1;
            long_nxt_s      = 1'b1;
          end else begin
            hold_nxt_s = r_hold + 16'd1;
          end
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_REL_DEB: begin
        // Returning to HELD keeps r_hold and long_done, so a release glitch
        // only pauses the long-press timer and cannot re-arm o_long.
        if (btn_s) begin
          state_nxt_s = ST_HELD;
        end else if (i_pls_1k) begin
          if (r_deb == DEB_LAST) begin
            state_nxt_s = ST_IDLE;
            rel_nxt_s   = 1'b1;
          end else begin
            deb_nxt_s = r_deb + 16'd1;
          end
        end else begin
          state_nxt_s = ST_REL_DEB;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Debounced level follows the next state so it rises with o_go and falls
  // with o_release.
  assign pressed_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_REL_DEB);

  // State, counters and registered event outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r     <= ST_IDLE;
      r_deb       <= 16'd0;
      r_hold      <= 16'd0;
      long_done_r <= 1'b0;
      o_go        <= 1'b0;
      o_release   <= 1'b0;
      o_long      <= 1'b0;
      o_pressed   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      r_deb       <= deb_nxt_s;
      r_hold      <= hold_nxt_s;
      long_done_r <= long_done_nxt_s;
      o_go        <= go_nxt_s;
      o_release   <= rel_nxt_s;
      o_long      <= long_nxt_s;
      o_pressed   <= pressed_nxt_s;
    end
  end

endmodule

// File: tb/tb_btn_go_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_go_ctrl
//   Self-checking bench for btn_go_ctrl (DEB_MS=3, LONG_MS=10, active-low
//   button). A reference model tracks the debounced level as "ticks seen
//   while the synchronized button disagrees with the level" and the hold time
//   as "ticks seen while steadily pressed"; every cycle all four outputs are
//   compared against it, and each directed scenario additionally checks the
//   number of pulses it must produce.
// ---------------------------------------------------------------------------
module tb_btn_go_ctrl;

  localparam int DEB  = 3;
  localparam int LONG = 10;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic i_pls_1k = 1'b0;
  logic i_btn = 1'b1;
  logic o_go, o_release, o_long, o_pressed;

  int n_cmp = 0;
  int n_bad = 0;
  int n_go = 0, n_rel = 0, n_long = 0;
  int tcnt = 0;
  int phase = 0;
  bit rand_tick = 1'b0;

  btn_go_ctrl #(.DEB_MS(DEB), .LONG_MS(LONG), .BTN_ACT_LOW(1'b1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_pls_1k(i_pls_1k), .i_btn(i_btn),
    .o_go(o_go), .o_release(o_release), .o_long(o_long), .o_pressed(o_pressed)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  logic [1:0] m_sync = 2'b11;  // raw pin delayed by the two synchronizer stages
  logic m_bs = 1'b0;
  logic m_lvl = 1'b0;          // debounced level
  logic m_disagree = 1'b0;     // button already disagreed with level last cycle
  int   m_dcnt = 0;            // ticks counted while disagreeing
  int   m_hcnt = 0;            // ticks counted while steadily held
  logic m_ldone = 1'b0;
  logic e_go = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_prs = 1'b0;

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      m_sync = 2'b11; m_lvl = 1'b0; m_disagree = 1'b0; m_dcnt = 0; m_hcnt = 0;
      m_ldone = 1'b0; e_go = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_prs = 1'b0;
    end else begin
      m_bs = ~m_sync[1];
      e_go = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      if (m_bs != m_lvl) begin
        // A tick only counts once the disagreement has lasted a full cycle.
        if (m_disagree && i_pls_1k) m_dcnt++;
        m_disagree = 1'b1;
        if (m_dcnt == DEB) begin
          m_lvl = m_bs; m_disagree = 1'b0; m_dcnt = 0;
          if (m_bs) begin
            e_go = 1'b1; m_hcnt = 0; m_ldone = 1'b0;
          end else begin
            e_rel = 1'b1;
          end
        end
      end else begin
        if (!m_disagree && m_lvl && i_pls_1k && !m_ldone) begin
          m_hcnt++;
          if (m_hcnt == LONG) begin
            m_ldone = 1'b1; e_long = 1'b1;
          end
        end
        m_disagree = 1'b0; m_dcnt = 0;
      end
      e_prs = m_lvl;
      m_sync = {m_sync[0], i_btn};
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs away from the active edge, count pulses, and
  // drive the tick for the next rising edge.
  task automatic step();
    @(negedge i_clk);
    chk("go",   int'(o_go),      int'(e_go));
    chk("rel",  int'(o_release), int'(e_rel));
    chk("long", int'(o_long),    int'(e_long));
    chk("prs",  int'(o_pressed), int'(e_prs));
    n_go   += int'(o_go);
    n_rel  += int'(o_release);
    n_long += int'(o_long);
    if (rand_tick) begin
      i_pls_1k = ($urandom_range(0, 2) == 0);
    end else begin
      phase    = tcnt;
      i_pls_1k = (tcnt == 9);
      tcnt     = (tcnt == 9) ? 0 : tcnt + 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int g0, r0, l0, hold_left;

  initial begin
    // Reset state
    run(3);
    chk("rst_go", int'(o_go), 0);
    chk("rst_prs", int'(o_pressed), 0);
    i_rstn = 1'b1;
    run(5);

    // Clean press (~5 ticks) then clean release
    g0 = n_go; r0 = n_rel; l0 = n_long;
    i_btn = 1'b0; run(55);
    i_btn = 1'b1; run(60);
    chk("A_go_cnt", n_go - g0, 1);
    chk("A_rel_cnt", n_rel - r0, 1);
    chk("A_long_cnt", n_long - l0, 0);

    // Bounce every 15 clocks for ~200 clocks, ending pressed
    g0 = n_go;
    for (int i = 0; i < 13; i++) begin
      i_btn = ~i_btn; run(15);
    end
    chk("B_bounce_go", n_go - g0, 0);
    run(60);
    chk("B_go_cnt", n_go - g0, 1);
    i_btn = 1'b1; run(60);

    // Long press held ~15 ticks
    g0 = n_go; l0 = n_long;
    i_btn = 1'b0; run(170);
    chk("C_go_cnt", n_go - g0, 1);
    chk("C_long_cnt", n_long - l0, 1);
    i_btn = 1'b1; run(60);

    // Release glitch of about one tick while held
    g0 = n_go; r0 = n_rel; l0 = n_long;
    i_btn = 1'b0; run(70);
    i_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk("D_prs_glitch", int'(o_pressed), 1);
    end
    i_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); chk("D_prs_resume", int'(o_pressed), 1);
    end
    run(100);
    chk("D_rel_cnt", n_rel - r0, 0);
    chk("D_long_cnt", n_long - l0, 1);
    chk("D_go_cnt", n_go - g0, 1);
    i_btn = 1'b1; run(60);

    // Bounce reaching btn_s on the same edge as the tick that would end the
    // press window (r_deb=2): bounce must win.
    for (int i = 0; i < 20 && phase != 7; i++) step();
    chk("E_align", phase, 7);
    g0 = n_go;
    i_btn = 1'b0; run(30);
    i_btn = 1'b1; run(60);
    chk("E_go_cnt", n_go - g0, 0);

    // Reset while held, button stays pressed through and after reset
    i_btn = 1'b0; run(80);
    chk("F_prs_before", int'(o_pressed), 1);
    i_rstn = 1'b0;
    #1;
    chk("F_rst_prs", int'(o_pressed), 0);
    chk("F_rst_go", int'(o_go), 0);
    chk("F_rst_rel", int'(o_release), 0);
    chk("F_rst_long", int'(o_long), 0);
    run(5);
    g0 = n_go;
    i_rstn = 1'b1; run(80);
    chk("F_go_cnt", n_go - g0, 1);
    i_btn = 1'b1; run(60);

    // Randomized button and tick activity with occasional resets
    rand_tick = 1'b1;
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        i_btn = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 40);
      end else begin
        hold_left--;
      end
      if ($urandom_range(0, 699) == 0) begin
        i_rstn = 1'b0; run(2); i_rstn = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
